clkdiv_sched: RTL

//  Programmable clock-divider controller/sequencer. Generates a divided clock (div_out) of

---
 rtl/clkdiv_sched_pkg.sv | 18 +
 rtl/clkdiv_core.sv | 93 +++++++++
 rtl/clkdiv_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clkdiv_sched_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_sched_pkg
// Shared definitions for the programmable clock-divider sequencer:
//   - state_e : sequencer state encoding (IDLE, RUN, DRAIN)
//   - MIN_DIV : smallest usable divide ratio; smaller requests clamp to it
// No ports (package).
// ----------------------------------------------------------------------------
package clkdiv_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int MIN_DIV = 2;

endpackage : clkdiv_sched_pkg

// File: rtl/clkdiv_core.sv
// ----------------------------------------------------------------------------
// clkdiv_core
// Period counter and waveform generator for the clock divider. Holds the
// active ratio, counts 0..N-1 and produces a registered, glitch-free div_out
// plus a tick pulse aligned with every div_out rising edge.
// Ports:
//   clk, nrst      system clock, asynchronous active-low reset
//   start_i        begin the first period (cnt=0, div_out=1, tick=1)
//   active_i       sequencer is in RUN or DRAIN, counter advances
//   finish_i       current boundary is the last one; park outputs low
//   ratio_load_i   load ratio_i as the active ratio at this edge
//   ratio_i        ratio to load (already clamped by the sequencer)
//   div_out_o      divided clock
//   tick_o         one-cycle pulse at each period start
//   boundary_o     combinational: last cycle of the current period
// ----------------------------------------------------------------------------
module clkdiv_core #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 3
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start_i,
   input  logic             active_i,
   input  logic             finish_i,
   input  logic             ratio_load_i,
   input  logic [CNT_W-1:0] ratio_i,
   output logic             div_out_o,
   output logic             tick_o,
   output logic             boundary_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] ratio_q, ratio_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] half;
   logic             div_q, div_d;
   logic             tick_q, tick_d;

   // (N+1)>>1 computed as (N>>1)+N[0] so N = 2^CNT_W-1 cannot overflow.
   assign half       = (ratio_q >> 1) + {{(CNT_W-1){1'b0}}, ratio_q[0]};
   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign boundary_o = active_i && (cnt_q == (ratio_q - CNT_W'(1)));

   // div_out is computed from the next count value so the registered output
   // lines up with the count it describes; the first cycle of every period is
   // always high because half >= 1 for any ratio >= 2.
   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      tick_d  = 1'b0;
      ratio_d = ratio_load_i ? ratio_i : ratio_q;
      if (start_i) begin
         cnt_d  = '0;
         div_d  = 1'b1;
         tick_d = 1'b1;
      end else if (active_i) begin
         if (boundary_o) begin
            cnt_d = '0;
            if (finish_i) begin
               div_d = 1'b0;
            end else begin
               div_d  = 1'b1;
               tick_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_inc;
            div_d = (cnt_inc < half);
         end
      end else begin
         cnt_d = '0;
         div_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q   <= '0;
         ratio_q <= CNT_W'(DEF_DIV);
         div_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ratio_q <= ratio_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
      end
   end

   assign div_out_o = div_q;
   assign tick_o    = tick_q;

endmodule : clkdiv_core

// File: rtl/clkdiv_sched.sv
// ----------------------------------------------------------------------------
// clkdiv_sched
// Programmable clock-divider controller/sequencer. Runs the divider core
// under a start/stop/burst FSM and offers a valid/ready config port whose
// ratio changes take effect only on period boundaries.
// Ports:
//   clk, nrst   system clock, asynchronous active-low reset
//   cfg_valid   new ratio offered
//   cfg_ready   no ratio pending; handshake completes on valid&ready
//   cfg_div     requested ratio (0/1 clamp to 2)
//   cfg_burst   periods per run, sampled at start; 0 = free-run
//   start       begin a run (IDLE only)
//   stop        end run after the current period (RUN only)
//   busy        sequencer not idle
//   div_out     divided clock
//   tick        one-cycle pulse at each div_out rising edge
//   done        one-cycle pulse when the sequencer returns to IDLE
// ----------------------------------------------------------------------------
module clkdiv_sched
   import clkdiv_sched_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 3
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_burst,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             div_out,
   output logic             tick,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_flag_q, pend_flag_d;
   logic             done_q, done_d;

   logic             cfg_accept;
   logic [CNT_W-1:0] cfg_div_clamped;
   logic             core_start;
   logic             core_finish;
   logic             ratio_load;
   logic [CNT_W-1:0] ratio_new;
   logic             boundary;

   assign cfg_accept      = cfg_valid && !pend_flag_q;
   assign cfg_div_clamped = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;

   // In RUN a nonzero bcnt always means a burst is in progress (it would
   // already have moved to DRAIN on reaching zero), so bcnt==0 doubles as the
   // free-run marker and no separate mode flag is needed.
   // A ratio offered on the very boundary that ends DRAIN goes straight into
   // the core, since no period is left in flight to protect.
   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      pend_div_d  = pend_div_q;
      pend_flag_d = pend_flag_q;
      done_d      = 1'b0;
      core_start  = 1'b0;
      core_finish = 1'b0;
      ratio_load  = 1'b0;
      ratio_new   = pend_div_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_accept) begin
               ratio_load = 1'b1;
               ratio_new  = cfg_div_clamped;
            end
            if (start) begin
               core_start = 1'b1;
               if (cfg_burst == '0) begin
                  bcnt_d  = '0;
                  state_d = ST_RUN;
               end else begin
                  bcnt_d  = cfg_burst - CNT_W'(1);
                  state_d = (cfg_burst == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (boundary && (bcnt_q != '0)) begin
               bcnt_d = bcnt_q - CNT_W'(1);
               if (bcnt_q == CNT_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
            if (stop) begin
               state_d = ST_DRAIN;
            end
            if (boundary && pend_flag_q) begin
               ratio_load  = 1'b1;
               ratio_new   = pend_div_q;
               pend_flag_d = 1'b0;
            end else if (cfg_accept) begin
               pend_div_d  = cfg_div_clamped;
               pend_flag_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (boundary) begin
               core_finish = 1'b1;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
               if (pend_flag_q) begin
                  ratio_load  = 1'b1;
                  ratio_new   = pend_div_q;
                  pend_flag_d = 1'b0;
               end else if (cfg_accept) begin
                  ratio_load = 1'b1;
                  ratio_new  = cfg_div_clamped;
               end
            end else if (cfg_accept) begin
               pend_div_d  = cfg_div_clamped;
               pend_flag_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         bcnt_q      <= '0;
         pend_div_q  <= '0;
         pend_flag_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         pend_div_q  <= pend_div_d;
         pend_flag_q <= pend_flag_d;
         done_q      <= done_d;
      end
   end

   clkdiv_core #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) u_core (
      .clk          (clk),
      .nrst         (nrst),
      .start_i      (core_start),
      .active_i     (busy),
      .finish_i     (core_finish),
      .ratio_load_i (ratio_load),
      .ratio_i      (ratio_new),
      .div_out_o    (div_out),
      .tick_o       (tick),
      .boundary_o   (boundary)
   );

   assign busy      = (state_q != ST_IDLE);
   assign cfg_ready = !pend_flag_q;
   assign done      = done_q;

endmodule : clkdiv_sched
